// File: rtl/axi4_fragmenter_lite_if.sv
// Bus bundle for axi4_fragmenter_lite: master-facing (in_*) and fragment-facing (out_*) channels.
// The slave modport is the fragmenter's view; master is the environment's view.
interface axi4_fragmenter_lite_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic                in_aw_valid;
  logic                in_aw_ready;
  logic [ID_W-1:0]     in_aw_bits_id;
  logic [ADDR_W-1:0]   in_aw_bits_addr;
  logic [7:0]          in_aw_bits_len;
  logic [2:0]          in_aw_bits_size;
  logic [1:0]          in_aw_bits_burst;
  logic                in_w_valid;
  logic                in_w_ready;
  logic [DATA_W-1:0]   in_w_bits_data;
  logic [DATA_W/8-1:0] in_w_bits_strb;
  logic                in_w_bits_last;
  logic                in_b_valid;
  logic                in_b_ready;
  logic [ID_W-1:0]     in_b_bits_id;
  logic [1:0]          in_b_bits_resp;
  logic                in_ar_valid;
  logic                in_ar_ready;
  logic [ID_W-1:0]     in_ar_bits_id;
  logic [ADDR_W-1:0]   in_ar_bits_addr;
  logic [7:0]          in_ar_bits_len;
  logic [2:0]          in_ar_bits_size;
  logic [1:0]          in_ar_bits_burst;
  logic                in_r_valid;
  logic                in_r_ready;
  logic [ID_W-1:0]     in_r_bits_id;
  logic [DATA_W-1:0]   in_r_bits_data;
  logic [1:0]          in_r_bits_resp;
  logic                in_r_bits_last;

  logic                out_aw_valid;
  logic                out_aw_ready;
  logic [ID_W-1:0]     out_aw_bits_id;
  logic [ADDR_W-1:0]   out_aw_bits_addr;
  logic                out_aw_bits_echo_real_last;
  logic                out_w_valid;
  logic                out_w_ready;
  logic [DATA_W-1:0]   out_w_bits_data;
  logic [DATA_W/8-1:0] out_w_bits_strb;
  logic                out_b_valid;
  logic                out_b_ready;
  logic [ID_W-1:0]     out_b_bits_id;
  logic [1:0]          out_b_bits_resp;
  logic                out_b_bits_echo_real_last;
  logic                out_ar_valid;
  logic                out_ar_ready;
  logic [ID_W-1:0]     out_ar_bits_id;
  logic [ADDR_W-1:0]   out_ar_bits_addr;
  logic                out_ar_bits_echo_real_last;
  logic                out_r_valid;
  logic                out_r_ready;
  logic [ID_W-1:0]     out_r_bits_id;
  logic [DATA_W-1:0]   out_r_bits_data;
  logic [1:0]          out_r_bits_resp;
  logic                out_r_bits_echo_real_last;

  modport slave (
    input  in_aw_valid, in_aw_bits_id, in_aw_bits_addr, in_aw_bits_len, in_aw_bits_size, in_aw_bits_burst,
    output in_aw_ready,
    input  in_w_valid, in_w_bits_data, in_w_bits_strb, in_w_bits_last,
    output in_w_ready,
    output in_b_valid, in_b_bits_id, in_b_bits_resp,
    input  in_b_ready,
    input  in_ar_valid, in_ar_bits_id, in_ar_bits_addr, in_ar_bits_len, in_ar_bits_size, in_ar_bits_burst,
    output in_ar_ready,
    output in_r_valid, in_r_bits_id, in_r_bits_data, in_r_bits_resp, in_r_bits_last,
    input  in_r_ready,
    output out_aw_valid, out_aw_bits_id, out_aw_bits_addr, out_aw_bits_echo_real_last,
    input  out_aw_ready,
    output out_w_valid, out_w_bits_data, out_w_bits_strb,
    input  out_w_ready,
    input  out_b_valid, out_b_bits_id, out_b_bits_resp, out_b_bits_echo_real_last,
    output out_b_ready,
    output out_ar_valid, out_ar_bits_id, out_ar_bits_addr, out_ar_bits_echo_real_last,
    input  out_ar_ready,
    input  out_r_valid, out_r_bits_id, out_r_bits_data, out_r_bits_resp, out_r_bits_echo_real_last,
    output out_r_ready
  );

  modport master (
    output in_aw_valid, in_aw_bits_id, in_aw_bits_addr, in_aw_bits_len, in_aw_bits_size, in_aw_bits_burst,
    input  in_aw_ready,
    output in_w_valid, in_w_bits_data, in_w_bits_strb, in_w_bits_last,
    input  in_w_ready,
    input  in_b_valid, in_b_bits_id, in_b_bits_resp,
    output in_b_ready,
    output in_ar_valid, in_ar_bits_id, in_ar_bits_addr, in_ar_bits_len, in_ar_bits_size, in_ar_bits_burst,
    input  in_ar_ready,
    input  in_r_valid, in_r_bits_id, in_r_bits_data, in_r_bits_resp, in_r_bits_last,
    output in_r_ready,
    input  out_aw_valid, out_aw_bits_id, out_aw_bits_addr, out_aw_bits_echo_real_last,
    output out_aw_ready,
    input  out_w_valid, out_w_bits_data, out_w_bits_strb,
    output out_w_ready,
    output out_b_valid, out_b_bits_id, out_b_bits_resp, out_b_bits_echo_real_last,
    input  out_b_ready,
    input  out_ar_valid, out_ar_bits_id, out_ar_bits_addr, out_ar_bits_echo_real_last,
    output out_ar_ready,
    output out_r_valid, out_r_bits_id, out_r_bits_data, out_r_bits_resp, out_r_bits_echo_real_last,
    input  out_r_ready
  );
endinterface

// File: rtl/axi4_fragmenter_lite.sv
// Splits AXI4 bursts into single-beat fragments tagged with echo_real_last, and
// rebuilds bursts on the way back (merged B response, R last from the echoed tag).
//
// Fragment engine states (one engine for AW, one for AR):
//   state | meaning
//   IDLE  | next fragment is the first beat, taken straight from the master's request
//   BUSY  | mid-burst; address and remaining count come from the engine registers
module axi4_fragmenter_lite #(
  parameter int ID_W         = 4,
  parameter int ADDR_W       = 30,
  parameter int DATA_W       = 32,
  parameter int W_CREDIT_MAX = 8
) (
  input logic clock,
  input logic reset,
  axi4_fragmenter_lite_if.slave bus
);
  localparam int CREDIT_W = $clog2(W_CREDIT_MAX + 1);
  localparam int NUM_ID   = 1 << ID_W;

  typedef enum logic {IDLE, BUSY} engState_e;

  function automatic logic [ADDR_W-1:0] nextAddr(input logic [ADDR_W-1:0] addr,
                                                 input logic [7:0] len,
                                                 input logic [2:0] size,
                                                 input logic [1:0] burst);
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] mask;
    incr = addr + (ADDR_W'(1) << size);
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    case (burst)
      2'd0:    nextAddr = addr;
      2'd2:    nextAddr = (addr & ~mask) | (incr & mask);
      default: nextAddr = incr;
    endcase
  endfunction

  engState_e         awState, arState;
  logic [7:0]        awRemQ, arRemQ;
  logic [ADDR_W-1:0] awAddrQ, arAddrQ;
  logic [7:0]        awRem, arRem;
  logic [ADDR_W-1:0] awAddr, arAddr;
  logic [CREDIT_W-1:0] credit;
  logic creditOk, creditAvail, awFire, arFire, wFire;

  assign awRem  = (awState == BUSY) ? awRemQ  : bus.in_aw_bits_len;
  assign awAddr = (awState == BUSY) ? awAddrQ : bus.in_aw_bits_addr;
  assign arRem  = (arState == BUSY) ? arRemQ  : bus.in_ar_bits_len;
  assign arAddr = (arState == BUSY) ? arAddrQ : bus.in_ar_bits_addr;

  // AW issue is throttled so at most W_CREDIT_MAX fragments wait for their W beat
  assign creditOk    = credit < CREDIT_W'(W_CREDIT_MAX);
  assign creditAvail = credit != '0;

  assign bus.out_aw_valid               = bus.in_aw_valid & creditOk;
  assign bus.out_aw_bits_id             = bus.in_aw_bits_id;
  assign bus.out_aw_bits_addr           = awAddr;
  assign bus.out_aw_bits_echo_real_last = (awRem == 8'd0);
  assign bus.in_aw_ready                = bus.out_aw_ready & creditOk & (awRem == 8'd0);
  assign awFire                         = bus.out_aw_valid & bus.out_aw_ready;

  assign bus.out_ar_valid               = bus.in_ar_valid;
  assign bus.out_ar_bits_id             = bus.in_ar_bits_id;
  assign bus.out_ar_bits_addr           = arAddr;
  assign bus.out_ar_bits_echo_real_last = (arRem == 8'd0);
  assign bus.in_ar_ready                = bus.out_ar_ready & (arRem == 8'd0);
  assign arFire                         = bus.out_ar_valid & bus.out_ar_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      awState <= IDLE;
      awRemQ  <= '0;
      awAddrQ <= '0;
    end else if (awFire) begin
      if (awRem != 8'd0) begin
        awState <= BUSY;
        awRemQ  <= awRem - 8'd1;
        awAddrQ <= nextAddr(awAddr, bus.in_aw_bits_len, bus.in_aw_bits_size, bus.in_aw_bits_burst);
      end else begin
        awState <= IDLE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      arState <= IDLE;
      arRemQ  <= '0;
      arAddrQ <= '0;
    end else if (arFire) begin
      if (arRem != 8'd0) begin
        arState <= BUSY;
        arRemQ  <= arRem - 8'd1;
        arAddrQ <= nextAddr(arAddr, bus.in_ar_bits_len, bus.in_ar_bits_size, bus.in_ar_bits_burst);
      end else begin
        arState <= IDLE;
      end
    end
  end

  assign bus.out_w_valid     = bus.in_w_valid & creditAvail;
  assign bus.in_w_ready      = bus.out_w_ready & creditAvail;
  assign bus.out_w_bits_data = bus.in_w_bits_data;
  assign bus.out_w_bits_strb = bus.in_w_bits_strb;
  assign wFire               = bus.in_w_valid & bus.out_w_ready & creditAvail;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      credit <= '0;
    end else begin
      case ({awFire, wFire})
        2'b10:   credit <= credit + CREDIT_W'(1);
        2'b01:   credit <= credit - CREDIT_W'(1);
        default: credit <= credit;
      endcase
    end
  end

  // Worst response seen so far per id; intermediate B beats are swallowed here
  logic [1:0] acc [NUM_ID];
  logic [1:0] accCur, mergedResp;
  logic       bEcho;

  assign bEcho      = bus.out_b_bits_echo_real_last;
  assign accCur     = acc[bus.out_b_bits_id];
  assign mergedResp = (bus.out_b_bits_resp > accCur) ? bus.out_b_bits_resp : accCur;

  assign bus.in_b_valid     = bus.out_b_valid & bEcho;
  assign bus.out_b_ready    = bEcho ? bus.in_b_ready : 1'b1;
  assign bus.in_b_bits_id   = bus.out_b_bits_id;
  assign bus.in_b_bits_resp = mergedResp;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ID; i++) acc[i] <= 2'b00;
    end else if (bus.out_b_valid && bus.out_b_ready) begin
      acc[bus.out_b_bits_id] <= bEcho ? 2'b00 : mergedResp;
    end
  end

  assign bus.in_r_valid     = bus.out_r_valid;
  assign bus.out_r_ready    = bus.in_r_ready;
  assign bus.in_r_bits_id   = bus.out_r_bits_id;
  assign bus.in_r_bits_data = bus.out_r_bits_data;
  assign bus.in_r_bits_resp = bus.out_r_bits_resp;
  assign bus.in_r_bits_last = bus.out_r_bits_echo_real_last;
endmodule

// File: tb/tb_axi4_fragmenter_lite.sv
// Directed and randomized bench for axi4_fragmenter_lite; expected fragment addresses,
// credit limits and merged responses come from a burst-level reference model.
module tb_axi4_fragmenter_lite;
  localparam int ID_W = 4;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int WMAX = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  axi4_fragmenter_lite_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

  axi4_fragmenter_lite #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .W_CREDIT_MAX(WMAX)) dut (
    .clock(clock),
    .reset(reset),
    .bus(ifc.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Address of beat i of a burst, computed directly from the burst rules
  function automatic logic [ADDR_W-1:0] refAddr(input longint a, input int len, input int size,
                                                input int burst, input int i);
    longint bytes, blk, base;
    bytes = longint'(1) << size;
    blk   = longint'(len + 1) * bytes;
    if (burst == 0) return ADDR_W'(a);
    if (burst == 2) begin
      base = a - (a % blk);
      return ADDR_W'(base + ((a - base + longint'(i) * bytes) % blk));
    end
    return ADDR_W'(a + longint'(i) * bytes);
  endfunction

  task automatic idleInputs();
    ifc.in_aw_valid = 0; ifc.in_aw_bits_id = '0; ifc.in_aw_bits_addr = '0;
    ifc.in_aw_bits_len = '0; ifc.in_aw_bits_size = '0; ifc.in_aw_bits_burst = '0;
    ifc.in_w_valid = 0; ifc.in_w_bits_data = '0; ifc.in_w_bits_strb = '0; ifc.in_w_bits_last = 0;
    ifc.in_b_ready = 0;
    ifc.in_ar_valid = 0; ifc.in_ar_bits_id = '0; ifc.in_ar_bits_addr = '0;
    ifc.in_ar_bits_len = '0; ifc.in_ar_bits_size = '0; ifc.in_ar_bits_burst = '0;
    ifc.in_r_ready = 0;
    ifc.out_aw_ready = 0; ifc.out_w_ready = 0; ifc.out_ar_ready = 0;
    ifc.out_b_valid = 0; ifc.out_b_bits_id = '0; ifc.out_b_bits_resp = '0; ifc.out_b_bits_echo_real_last = 0;
    ifc.out_r_valid = 0; ifc.out_r_bits_id = '0; ifc.out_r_bits_data = '0; ifc.out_r_bits_resp = '0;
    ifc.out_r_bits_echo_real_last = 0;
  endtask

  // mode 0: downstream always ready; 1: random handshakes; 2: out_aw_ready from pat, then 1
  task automatic awRun(input int id, input longint addr, input int len, input int size, input int burst,
                       input int awDelay, input int wHold, input int mode, input logic [15:0] pat);
    int beat = 0, wSent = 0, credit = 0, cyc = 0;
    logic awv, ardy, wv, wr, awF, wF;
    logic [DATA_W-1:0] wd;
    logic [DATA_W/8-1:0] ws;
    ifc.in_aw_bits_id = ID_W'(id); ifc.in_aw_bits_addr = ADDR_W'(addr);
    ifc.in_aw_bits_len = 8'(len); ifc.in_aw_bits_size = 3'(size); ifc.in_aw_bits_burst = 2'(burst);
    while ((beat <= len || wSent <= len) && cyc < 3000) begin
      awv  = (cyc >= awDelay) && (beat <= len);
      ardy = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode == 2 && cyc < 16) ? pat[cyc] : 1'b1;
      wv   = (wSent <= len) && ((mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1);
      wr   = (cyc < wHold) ? 1'b0 : ((mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1);
      wd = $urandom; ws = 4'($urandom);
      ifc.in_aw_valid = awv; ifc.out_aw_ready = ardy;
      ifc.in_w_valid = wv; ifc.in_w_bits_data = wd; ifc.in_w_bits_strb = ws;
      ifc.in_w_bits_last = (wSent == len); ifc.out_w_ready = wr;
      @(negedge clock);
      chk("aw_out_valid", ifc.out_aw_valid, awv && credit < WMAX);
      if (awv) begin
        chk("aw_addr", ifc.out_aw_bits_addr, refAddr(addr, len, size, burst, beat));
        chk("aw_echo", ifc.out_aw_bits_echo_real_last, beat == len);
        chk("aw_id", ifc.out_aw_bits_id, id);
        chk("aw_in_ready", ifc.in_aw_ready, ardy && credit < WMAX && beat == len);
      end
      chk("w_out_valid", ifc.out_w_valid, wv && credit != 0);
      chk("w_in_ready", ifc.in_w_ready, wr && credit != 0);
      if (wv) begin
        chk("w_data", ifc.out_w_bits_data, wd);
        chk("w_strb", ifc.out_w_bits_strb, ws);
      end
      awF = awv && ardy && credit < WMAX;
      wF  = wv && wr && credit != 0;
      @(posedge clock); #1;
      if (awF) begin beat++; credit++; end
      if (wF) begin wSent++; credit--; end
      cyc++;
    end
    chk("aw_done", beat, len + 1);
    chk("w_done", wSent, len + 1);
    ifc.in_aw_valid = 0; ifc.in_w_valid = 0; ifc.out_aw_ready = 0; ifc.out_w_ready = 0;
  endtask

  task automatic arRun(input int id, input longint addr, input int len, input int size, input int burst,
                       input int mode);
    int beat = 0, cyc = 0;
    logic ardy;
    ifc.in_ar_bits_id = ID_W'(id); ifc.in_ar_bits_addr = ADDR_W'(addr);
    ifc.in_ar_bits_len = 8'(len); ifc.in_ar_bits_size = 3'(size); ifc.in_ar_bits_burst = 2'(burst);
    ifc.in_ar_valid = 1;
    while (beat <= len && cyc < 3000) begin
      ardy = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      ifc.out_ar_ready = ardy;
      @(negedge clock);
      chk("ar_out_valid", ifc.out_ar_valid, 1);
      chk("ar_addr", ifc.out_ar_bits_addr, refAddr(addr, len, size, burst, beat));
      chk("ar_echo", ifc.out_ar_bits_echo_real_last, beat == len);
      chk("ar_id", ifc.out_ar_bits_id, id);
      chk("ar_in_ready", ifc.in_ar_ready, ardy && beat == len);
      @(posedge clock); #1;
      if (ardy) beat++;
      cyc++;
    end
    chk("ar_done", beat, len + 1);
    ifc.in_ar_valid = 0; ifc.out_ar_ready = 0;
  endtask

  task automatic bBeat(input int id, input int resp, input bit echo, input int expResp, input bit rnd);
    int cyc = 0;
    bit fired = 0;
    logic brdy;
    ifc.out_b_valid = 1; ifc.out_b_bits_id = ID_W'(id); ifc.out_b_bits_resp = 2'(resp);
    ifc.out_b_bits_echo_real_last = echo;
    while (!fired && cyc < 200) begin
      brdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ifc.in_b_ready = brdy;
      @(negedge clock);
      chk("b_out_ready", ifc.out_b_ready, echo ? brdy : 1'b1);
      chk("b_in_valid", ifc.in_b_valid, echo);
      if (echo) begin
        chk("b_resp", ifc.in_b_bits_resp, expResp);
        chk("b_id", ifc.in_b_bits_id, id);
      end
      @(posedge clock); #1;
      fired = !echo || brdy;
      cyc++;
    end
    chk("b_fired", fired, 1);
    ifc.out_b_valid = 0; ifc.in_b_ready = 0;
  endtask

  task automatic bRun(input int id, input int n, input logic [31:0] resps, input bit rnd);
    int mx = 0;
    int r;
    for (int i = 0; i < n; i++) begin
      r = int'(resps[2*i +: 2]);
      if (r > mx) mx = r;
    end
    for (int i = 0; i < n; i++) bBeat(id, int'(resps[2*i +: 2]), i == n - 1, mx, rnd);
    @(negedge clock);
    chk("b_single", ifc.in_b_valid, 0);
    @(posedge clock); #1;
  endtask

  task automatic rRun(input int n, input bit rnd);
    int cyc;
    bit fired;
    logic rrdy;
    logic [ID_W-1:0] id;
    logic [DATA_W-1:0] d;
    logic [1:0] rs;
    for (int i = 0; i < n; i++) begin
      id = ID_W'($urandom); d = $urandom; rs = 2'($urandom);
      ifc.out_r_valid = 1; ifc.out_r_bits_id = id; ifc.out_r_bits_data = d;
      ifc.out_r_bits_resp = rs; ifc.out_r_bits_echo_real_last = (i == n - 1);
      cyc = 0; fired = 0;
      while (!fired && cyc < 200) begin
        rrdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        ifc.in_r_ready = rrdy;
        @(negedge clock);
        chk("r_valid", ifc.in_r_valid, 1);
        chk("r_id", ifc.in_r_bits_id, id);
        chk("r_data", ifc.in_r_bits_data, d);
        chk("r_resp", ifc.in_r_bits_resp, rs);
        chk("r_last", ifc.in_r_bits_last, i == n - 1);
        chk("r_out_ready", ifc.out_r_ready, rrdy);
        @(posedge clock); #1;
        fired = rrdy;
        cyc++;
      end
      chk("r_fired", fired, 1);
    end
    ifc.out_r_valid = 0; ifc.in_r_ready = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired: vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    int id, size, burst, len, n;
    longint a;
    logic [31:0] resps;
    int lens[4];
    lens[0] = 1; lens[1] = 3; lens[2] = 7; lens[3] = 15;

    idleInputs();
    reset = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_aw_valid", ifc.out_aw_valid, 0);
    chk("rst_ar_valid", ifc.out_ar_valid, 0);
    chk("rst_w_valid", ifc.out_w_valid, 0);
    chk("rst_w_ready", ifc.in_w_ready, 0);
    chk("rst_b_valid", ifc.in_b_valid, 0);
    chk("rst_r_valid", ifc.in_r_valid, 0);
    @(posedge clock); #1;
    reset = 1;
    @(posedge clock); #1;

    // AR INCR burst and its read data
    arRun(3, 'h100, 3, 2, 1, 0);
    rRun(4, 0);

    // AW len=1 with SLVERR then OKAY, then a single OKAY proving the accumulator cleared
    awRun(5, 'h200, 1, 2, 1, 0, 0, 0, 16'h0);
    bRun(5, 2, 32'b00_10, 0);
    bRun(5, 1, 32'b00, 0);

    // WRAP on both channels
    arRun(2, 'h1C, 3, 2, 2, 0);
    awRun(2, 'h1C, 3, 2, 2, 0, 0, 0, 16'h0);
    bRun(2, 4, 32'h0, 0);

    // W beats waiting before the AW fragment
    awRun(6, 'h300, 0, 2, 1, 3, 0, 0, 16'h0);
    bRun(6, 1, 32'h1, 0);

    // Credit cap: W held off while 16 fragments try to issue
    awRun(7, 'h400, 15, 2, 1, 0, 14, 0, 16'h0);
    bRun(7, 16, 32'h0000_0300, 1);

    // Downstream AW stall 1,0,0,1 inside a len=2 burst
    awRun(8, 'h500, 2, 2, 1, 0, 0, 2, 16'b1001);
    bRun(8, 3, 32'b01_11_00, 0);

    // Interleaved ids keep separate accumulators
    bBeat(2, 3, 0, 0, 0);
    bBeat(7, 1, 0, 0, 0);
    bBeat(7, 0, 1, 1, 0);
    bBeat(2, 0, 1, 3, 0);

    // Reset in the middle of bursts
    ifc.in_ar_bits_id = 1; ifc.in_ar_bits_addr = 'h400; ifc.in_ar_bits_len = 7;
    ifc.in_ar_bits_size = 2; ifc.in_ar_bits_burst = 1; ifc.in_ar_valid = 1; ifc.out_ar_ready = 1;
    ifc.in_aw_bits_id = 1; ifc.in_aw_bits_addr = 'h600; ifc.in_aw_bits_len = 3;
    ifc.in_aw_bits_size = 2; ifc.in_aw_bits_burst = 1; ifc.in_aw_valid = 1; ifc.out_aw_ready = 1;
    ifc.out_b_valid = 1; ifc.out_b_bits_id = 9; ifc.out_b_bits_resp = 3; ifc.out_b_bits_echo_real_last = 0;
    repeat (2) @(posedge clock);
    #1;
    idleInputs();
    reset = 0;
    ifc.in_w_valid = 1; ifc.out_w_ready = 1;
    @(negedge clock);
    chk("rst_mid_ar_valid", ifc.out_ar_valid, 0);
    chk("rst_mid_w_ready", ifc.in_w_ready, 0);
    @(posedge clock); #1;
    reset = 1;
    ifc.in_w_valid = 0; ifc.out_w_ready = 0;
    @(posedge clock); #1;
    arRun(1, 'h800, 1, 2, 1, 0);
    awRun(1, 'h900, 1, 2, 1, 0, 0, 0, 16'h0);
    bBeat(9, 0, 1, 0, 0);
    bRun(1, 2, 32'h0, 0);

    // Randomized bursts on all channels
    for (int k = 0; k < 25; k++) begin
      id    = int'($urandom_range(0, 15));
      size  = int'($urandom_range(0, 2));
      burst = int'($urandom_range(0, 3));
      len   = (burst == 2) ? lens[$urandom_range(0, 3)] : int'($urandom_range(0, 9));
      a     = longint'($urandom_range(0, 32'h3FFF_FFFF));
      a     = a & ~((longint'(1) << size) - 1);
      if (k == 0) a = 'h3FFF_FFF8;
      awRun(id, a, len, size, burst, int'($urandom_range(0, 2)), 0, 1, 16'h0);
      n = len + 1;
      resps = $urandom;
      bRun(id, (n > 16) ? 16 : n, resps, 1);
      arRun(id, a, len, size, burst, 1);
      rRun(len + 1, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axi4_fragmenter_lite.md
Name: axi4_fragmenter_lite

Overview:
- Sits directly upstream of the AXI4 output buffer stage.
- Converts full AXI4 bursts (len/size/burst) from a master into single-beat AXI4 transactions.
- Tags every fragment with echo_real_last so the downstream buffer and slave can carry it back.
- On the return paths, merges B responses and regenerates R last from the echoed flag, so the master sees ordinary bursts.

Parameters:
- ID_W, 4, AXI id width.
- ADDR_W, 30, address width.
- DATA_W, 32, data width; beat size must be ≤ log2(DATA_W/8).
- W_CREDIT_MAX, 8, maximum AW fragments issued whose W beat has not yet been sent.

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- in_aw_valid/ready  in/out  1  master AW handshake
- in_aw_bits_id/addr/len/size/burst  in  ID_W/ADDR_W/8/3/2  master AW burst
- in_w_valid/ready  in/out  1  master W handshake
- in_w_bits_data/strb/last  in  DATA_W/DATA_W/8/1  master W beat
- in_b_valid/ready  out/in  1  master B handshake
- in_b_bits_id/resp  out  ID_W/2  merged write response
- in_ar_*  (same fields as in_aw_*)  master AR burst
- in_r_valid/ready  out/in  1  master R handshake
- in_r_bits_id/data/resp/last  out  ID_W/DATA_W/2/1  read beat
- out_aw_valid/ready  out/in  1  fragment AW handshake
- out_aw_bits_id/addr/echo_real_last  out  ID_W/ADDR_W/1
- out_w_valid/ready  out/in  1  fragment W handshake
- out_w_bits_data/strb  out  DATA_W/DATA_W/8
- out_b_valid/ready  in/out  1  fragment B handshake
- out_b_bits_id/resp/echo_real_last  in  ID_W/2/1
- out_ar_*  (same as out_aw_*)
- out_r_valid/ready  in/out  1  fragment R handshake
- out_r_bits_id/data/resp/echo_real_last  in  ID_W/DATA_W/2/1

Behaviour:
- Reset (reset low, asynchronous): both fragment engines not busy, remaining counts 0, W credit 0, all 16 B accumulators 0 (OKAY).
- Outputs after reset: out_*_valid and in_b_valid follow inputs combinationally, so they are 0 whenever no input is valid.
- Fragment engine (one for AW, one for AR), states IDLE/BUSY:
  - rem = BUSY ? r_rem : in_len; addr = BUSY ? r_addr : in_addr.
  - out_ax_valid = in_ax_valid; out id = in id; echo_real_last = (rem == 0).
  - in_ax_ready = out_ax_ready & (rem == 0). The master holds the burst stable until accepted.
  - First fragment has zero latency: it is presented combinationally in the cycle in_ax_valid rises.
  - On an accepted fragment with rem != 0: BUSY, r_rem = rem - 1, r_addr = next(addr).
  - On an accepted fragment with rem == 0: IDLE.
- next(addr) by burst type:
  - FIXED (0): addr unchanged.
  - INCR (1): addr + (1 << size), modulo 2^ADDR_W.
  - WRAP (2): low bits wrap within an aligned block of (len+1) << size bytes; upper bits held.
  - Reserved (3): treated as INCR.
- AW only: fragment issue additionally requires credit < W_CREDIT_MAX.
- W credit: +1 per accepted AW fragment, -1 per accepted W beat; both in the same cycle leaves it unchanged.
- W path: out_w_valid = in_w_valid & (credit != 0); in_w_ready = out_w_ready & (credit != 0); data/strb pass through. in_w_bits_last is ignored.
- B path (echo_real_last = 0):
  - out_b_ready = 1 (response is consumed, not forwarded).
  - acc[id] = max(acc[id], resp).
- B path (echo_real_last = 1):
  - in_b_valid = out_b_valid; out_b_ready = in_b_ready.
  - in_b_resp = max(acc[id], resp); on handshake acc[id] is cleared to 0.
  - max() compares the numeric 2-bit resp value.
- R path: pure pass-through of valid/ready/id/data/resp; in_r_bits_last = out_r_bits_echo_real_last.
- Simultaneous AW and AR: independent, no arbitration.
- Downstream stall (out_ready = 0) mid-burst: engine holds r_addr/r_rem; the output stays stable.
- Reset mid-burst: all state returns to reset values. In-flight fragments are lost; the bench must not check them.

Test Plan:
- AR id=3 addr=0x100 len=3 size=2 INCR -> 4 out_ar fragments at 0x100/0x104/0x108/0x10C; echo_real_last=0,0,0,1; in_ar_ready only on the 4th.
- Same AR, slave returns 4 R beats with echo 0,0,0,1 -> in_r_last=0,0,0,1; data unchanged.
- AW len=1 size=2 addr=0x200 plus 2 W beats; slave B resp SLVERR(2) then OKAY(0) -> exactly one in_b with resp=2; acc[id] cleared afterwards.
- WRAP len=3 size=2 addr=0x1C -> fragments at 0x1C/0x10/0x14/0x18.
- W beats arrive 3 cycles before AW -> in_w_ready=0 until the first AW fragment is accepted. With out_aw_ready held high and out_w_ready=0, AW issue stops once credit reaches 8.
- out_aw_ready toggling 1,0,0,1 during a len=2 burst -> addresses stay stable while stalled; no beat is skipped or duplicated.
